instruction_fetch_queue: RTL and testbench

Parametrised fetch stage that decouples instruction-memory reads from decode with a FIFO_DEPTH-entry prefetch queue. It sits between the synchronous instruction memory and the IF/ID boundary. It issues sequential reads ahead of decode and absorbs decode stalls without losing fetched words. A single redirect port (branch/jump target, resolved downstream) flushes the queue and squashes any in-flight read.

---
 rtl/instruction_fetch_queue_if.sv | 33 +++
 rtl/instruction_fetch_queue.sv | 109 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Bundle of the fetch stage's memory, decode, redirect and debug signals.
// The slave modport is the fetch queue; the master modport is its surroundings.
interface instruction_fetch_queue_if #(
    parameter int NB_REG     = 32,
    parameter int NB_INSTR   = 32,
    parameter int LOG2_DEPTH = 2
);
    logic                  valid;
    logic [NB_REG-1:0]     imem_addr;
    logic                  imem_re;
    logic [NB_INSTR-1:0]   imem_data;
    logic [NB_INSTR-1:0]   ir;
    logic [NB_REG-1:0]     pc;
    logic                  ir_valid;
    logic                  ready;
    logic                  redirect;
    logic [NB_REG-1:0]     redirect_pc;
    logic                  misaligned;
    logic [NB_REG-1:0]     debug_system_pc;
    logic [LOG2_DEPTH:0]   debug_count;

    modport slave (
        input  valid, imem_data, ready, redirect, redirect_pc,
        output imem_addr, imem_re, ir, pc, ir_valid, misaligned,
               debug_system_pc, debug_count
    );

    modport master (
        output valid, imem_data, ready, redirect, redirect_pc,
        input  imem_addr, imem_re, ir, pc, ir_valid, misaligned,
               debug_system_pc, debug_count
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: issues sequential reads to a one-cycle instruction
// memory and buffers the returned words in a small queue in front of decode.
// A redirect flushes the queue, drops any returning word and restarts fetch.
module instruction_fetch_queue #(
    parameter int                 NB_REG     = 32,
    parameter int                 NB_INSTR   = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 LOG2_DEPTH = $clog2(FIFO_DEPTH),
    parameter logic [NB_REG-1:0]  RESET_PC   = '0,
    parameter logic [NB_INSTR-1:0] NOP_INSTR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_queue_if.slave  bus
);
    localparam int CW = LOG2_DEPTH + 1;

    logic [NB_REG-1:0]     fetch_pc;
    logic [NB_REG-1:0]     tag_pc;
    logic [NB_INSTR-1:0]   q_instr [FIFO_DEPTH];
    logic [NB_REG-1:0]     q_pc    [FIFO_DEPTH];
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic                  squash;
    logic                  misaligned;

    logic                  redirect_take;
    logic                  has_credit;
    logic                  issue;
    logic                  not_empty;
    logic                  pop;
    logic                  push;
    logic [CW:0]           committed;

    // Credit counts both stored words and the one still on its way back, so
    // a returning word always has a free slot even if decode never pops.
    always_comb begin
        redirect_take = bus.valid & bus.redirect;
        committed     = {1'b0, count} + {{CW{1'b0}}, inflight};
        has_credit    = committed < (CW+1)'(FIFO_DEPTH);
        issue         = ~rst & bus.valid & ~bus.redirect & has_credit;
        not_empty     = count != '0;
        pop           = bus.valid & bus.ready & not_empty & ~redirect_take;
        push          = inflight & ~squash & ~redirect_take;
    end

    // Queue storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]    <= tag_pc;
        end
    end

    // Fetch PC, queue bookkeeping, read tracking and the misalignment pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            tag_pc     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            squash     <= 1'b0;
            misaligned <= 1'b0;
        end else if (redirect_take) begin
            fetch_pc   <= {bus.redirect_pc[NB_REG-1:2], 2'b00};
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            squash     <= 1'b1;
            misaligned <= |bus.redirect_pc[1:0];
        end else begin
            squash     <= 1'b0;
            misaligned <= 1'b0;
            inflight   <= issue;
            if (issue) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + NB_REG'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Decode-facing outputs come from stored state only; reset forces them idle.
    always_comb begin
        bus.ir_valid        = ~rst & not_empty;
        bus.ir              = bus.ir_valid ? q_instr[rd_ptr] : NOP_INSTR;
        bus.pc              = bus.ir_valid ? (q_pc[rd_ptr] + NB_REG'(4)) : '0;
        bus.imem_re         = issue;
        bus.imem_addr       = fetch_pc;
        bus.misaligned      = misaligned;
        bus.debug_system_pc = fetch_pc;
        bus.debug_count     = count;
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised bench for instruction_fetch_queue against a queue-level model,
// with directed sequences whose expected values are worked out by hand.
module tb_instruction_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    instruction_fetch_queue_if #(.NB_REG(32), .NB_INSTR(32), .LOG2_DEPTH(2)) bus ();

    instruction_fetch_queue #(
        .NB_REG(32), .NB_INSTR(32), .FIFO_DEPTH(DEPTH), .LOG2_DEPTH(2),
        .RESET_PC(32'h0), .NOP_INSTR(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word stored at a byte address: word index k holds 0x1000 + k.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        bus.imem_data <= bus.imem_re ? mem_word(bus.imem_addr) : 32'hDEADBEEF;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit rdy, input bit redir,
                                 input logic [31:0] rpc, input bit rs);
        @(posedge clk);
        #1;
        bus.valid       = v;
        bus.ready       = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        rst             = rs;
    endtask

    // Reference model: fetch PC, a queue of {word, pc}, and the address of
    // the one read that may still be returning.
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    bit          m_pend;
    bit          m_mis;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        bit acc, iss, pp;
        if (rst) begin
            m_pc     = 32'h0;
            mq.delete();
            m_pend   = 1'b0;
            m_mis    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = bus.valid && bus.redirect;
            iss = bus.valid && !bus.redirect && ((mq.size() + int'(m_pend)) < DEPTH);
            pp  = bus.valid && bus.ready && (mq.size() > 0) && !acc;
            if (acc) begin
                mq.delete();
                m_pend = 1'b0;
                m_mis  = (bus.redirect_pc[1:0] != 2'b00);
                m_pc   = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                m_mis = 1'b0;
                if (pp) void'(mq.pop_front());
                if (m_pend) mq.push_back('{mem_word(m_pend_pc), m_pend_pc});
                if (iss) begin
                    m_pend_pc = m_pc;
                    m_pend    = 1'b1;
                    m_pc      = m_pc + 32'd4;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Every cycle, hold the DUT outputs against what the model says they must be.
    always @(negedge clk) begin
        bit          e_re, e_v;
        logic [31:0] e_ir, e_pc;
        if (model_ok) begin
            e_re = !rst && bus.valid && !bus.redirect && ((mq.size() + int'(m_pend)) < DEPTH);
            e_v  = !rst && (mq.size() > 0);
            e_ir = e_v ? mq[0].instr : 32'h0;
            e_pc = e_v ? (mq[0].pc + 32'd4) : 32'h0;
            checkOutput("imem_re", bus.imem_re, e_re);
            if (e_re) checkOutput("imem_addr", bus.imem_addr, m_pc);
            checkOutput("ir_valid", bus.ir_valid, e_v);
            checkOutput("ir", bus.ir, e_ir);
            checkOutput("pc", bus.pc, e_pc);
            if (!rst) begin
                checkOutput("misaligned", bus.misaligned, m_mis);
                checkOutput("debug_count", bus.debug_count, mq.size());
                checkOutput("debug_pc", bus.debug_system_pc, m_pc);
                checkOutput("count_bound", bus.debug_count <= DEPTH, 1'b1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          reads;
        bit          v, rdy, redir, rs;
        logic [31:0] rpc;
        n_cmp           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.valid       = 1'b0;
        bus.ready       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_data   = 32'h0;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Streaming from reset with decode always ready.
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s1_re_c0", bus.imem_re, 1);
        checkOutput("s1_addr_c0", bus.imem_addr, 32'h0);
        checkOutput("s1_irv_c0", bus.ir_valid, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s1_ir_c2", bus.ir, 32'h1000);
        checkOutput("s1_pc_c2", bus.pc, 32'h4);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s1_ir_c3", bus.ir, 32'h1001);
        checkOutput("s1_pc_c3", bus.pc, 32'h8);

        // Decode stalled from reset: the queue fills and issue stops.
        applyStimulus(0, 0, 0, 0, 1);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            @(negedge clk); #1;
            if (bus.imem_re) reads++;
        end
        checkOutput("s2_reads", reads, 4);
        checkOutput("s2_re_full", bus.imem_re, 0);
        checkOutput("s2_count_full", bus.debug_count, 4);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s2_ir_a0", bus.ir, 32'h1000);
        checkOutput("s2_re_a0", bus.imem_re, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s2_ir_a1", bus.ir, 32'h1001);
        checkOutput("s2_re_a1", bus.imem_re, 1);
        checkOutput("s2_addr_a1", bus.imem_addr, 32'h10);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s2_ir_a2", bus.ir, 32'h1002);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s2_ir_a3", bus.ir, 32'h1003);

        // Redirect with two entries queued and one read in flight.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h40, 0);
        @(negedge clk); #1;
        checkOutput("s3_count_r", bus.debug_count, 2);
        checkOutput("s3_re_r", bus.imem_re, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s3_count_r1", bus.debug_count, 0);
        checkOutput("s3_re_r1", bus.imem_re, 1);
        checkOutput("s3_addr_r1", bus.imem_addr, 32'h40);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s3_irv_r2", bus.ir_valid, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s3_ir_r3", bus.ir, 32'h1010);
        checkOutput("s3_pc_r3", bus.pc, 32'h44);

        // Misaligned redirect target.
        applyStimulus(1, 1, 1, 32'h46, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s4_mis_r1", bus.misaligned, 1);
        checkOutput("s4_addr_r1", bus.imem_addr, 32'h44);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s4_mis_r2", bus.misaligned, 0);

        // Fetch address wraps past the top of the address space.
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s5_addr_r1", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s5_addr_r2", bus.imem_addr, 32'h0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s5_ir_r3", bus.ir, 32'h4000_0FFF);
        checkOutput("s5_pc_r3", bus.pc, 32'h0);

        // Step enable low for three cycles mid-stream.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s6_re_v0", bus.imem_re, 0);
        checkOutput("s6_count_v0", bus.debug_count, 1);
        checkOutput("s6_dpc_v0", bus.debug_system_pc, 32'h10);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s6_count_v1", bus.debug_count, 2);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s6_count_v2", bus.debug_count, 2);
        checkOutput("s6_dpc_v2", bus.debug_system_pc, 32'h10);
        checkOutput("s6_ir_v2", bus.ir, 32'h1002);

        // Reset with three entries queued and a read in flight.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk); #1;
        checkOutput("s7_irv_rst", bus.ir_valid, 0);
        checkOutput("s7_re_rst", bus.imem_re, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s7_irv_r1", bus.ir_valid, 0);
        checkOutput("s7_ir_r1", bus.ir, 32'h0);
        checkOutput("s7_count_r1", bus.debug_count, 0);
        checkOutput("s7_addr_r1", bus.imem_addr, 32'h0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s7_count_r2", bus.debug_count, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("s7_count_r3", bus.debug_count, 1);
        checkOutput("s7_ir_r3", bus.ir, 32'h1000);

        // Random traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            v     = ($urandom_range(0, 9) < 8);
            rdy   = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 19) == 0);
            rs    = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & 32'hFF;
                1:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: rpc = 32'h100 + $urandom_range(0, 255);
            endcase
            applyStimulus(v, rdy, redir, rpc, rs);
        end
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
